dscan_mux: RTL and testbench

Parametrised multiplexed 7-segment/LED digit scanner: drives a bank of WIN common-anode digit selects from a window of WIN nibbles chosen out of NDATA input nibbles, with a programmable scan prescaler, 8-level brightness PWM per digit slot, and a tear-free window offset. It sits between the value-formatting logic and the board's anode/segment-decoder pins, and replaces the fixed 4-of-6, two-page, 50%-duty scanner.

---
 rtl/dscan_pkg.sv | 22 ++
 rtl/dscan_tick.sv | 42 ++++
 rtl/dscan_mux.sv | 125 ++++++++++++
 tb/tb_dscan_mux.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dscan_pkg.sv
// dscan_pkg: shared constants and helpers for the dscan_mux digit scanner.
//   SUBW/SUB_LAST : sub-step counter width and last value (8 sub-steps per slot)
//   FRAME_W       : width of the blink frame counter (DSCAN_BLINK_EN builds)
//   sa_off()      : all-ones (every digit dark) select pattern
//   one_cold()    : active-low select with a single zero at the given slot
// The helpers return MAXWIN bits; callers cast down to their own WIN.
package dscan_pkg;

    localparam int SUBW    = 3;
    localparam logic [SUBW-1:0] SUB_LAST = 3'd7;
    localparam int FRAME_W = 5;
    localparam int MAXWIN  = 32;

    function automatic logic [MAXWIN-1:0] sa_off();
        return '1;
    endfunction

    function automatic logic [MAXWIN-1:0] one_cold(input logic [4:0] slot);
        return ~(MAXWIN'(1) << slot);
    endfunction

endpackage

// File: rtl/dscan_tick.sv
// dscan_tick: scan prescaler. Counts enabled clocks 0..DIV-1 and emits a
// one-cycle step pulse on the last count.
//   clk_i    : system clock, rising edge
//   rst_i    : synchronous active-high reset
//   enable_i : count qualifier; the counter holds while low
//   step_o   : combinational step pulse (pre == DIV-1 and enable_i)
module dscan_tick
    import dscan_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic step_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign step_o = enable_i && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (step_o) begin
            pre_d = '0;
        end else if (enable_i) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/dscan_mux.sv
// dscan_mux: multiplexed digit scanner. Shows a WIN-nibble window, starting at
// a frame-latched offset, out of NDATA packed nibbles on WIN active-low digit
// selects, with 8-level per-slot brightness PWM.
//   CLK    : system clock, rising edge
//   RST    : synchronous active-high reset
//   ENABLE : scan advance qualifier (outputs still track live D/BRIGHT)
//   D      : NDATA*DW packed nibbles, nibble i = D[i*DW +: DW]
//   OFS    : window start index, taken only at frame start, ignored if >= NDATA
//   BRIGHT : lit sub-steps per slot, 0 = dark, 7 = 7/8 duty
//   BLINK  : per-slot blink enables (only when DSCAN_BLINK_EN is defined)
//   SA     : active-low digit selects, at most one low
//   L      : nibble for the lit digit, held while dark
// Build option DSCAN_BLINK_EN: adds BLINK and a 5-bit frame counter; slots with
// BLINK set go dark while frame counter bit 4 is set.
module dscan_mux
    import dscan_pkg::*;
#(
    parameter int WIN   = 4,
    parameter int NDATA = 6,
    parameter int DW    = 4,
    parameter int DIV   = 1,
    parameter int OW    = $clog2(NDATA)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ENABLE,
    input  logic [NDATA*DW-1:0] D,
    input  logic [OW-1:0]       OFS,
    input  logic [2:0]          BRIGHT,
`ifdef DSCAN_BLINK_EN
    input  logic [WIN-1:0]      BLINK,
`endif
    output logic [WIN-1:0]      SA,
    output logic [DW-1:0]       L
);

    localparam int SLW = $clog2(WIN);
    localparam logic [SLW-1:0] SLOT_LAST = SLW'(WIN - 1);
    localparam logic [OW:0]    NDATA_W   = (OW + 1)'(NDATA);

    logic            step;
    logic            frame_end;
    logic            blink_dark;
    logic            lit;
    logic [SUBW-1:0] sub_q, sub_d;
    logic [SLW-1:0]  slot_q, slot_d;
    logic [OW-1:0]   ofs_q, ofs_d;
    logic [WIN-1:0]  sa_q, sa_d;
    logic [DW-1:0]   l_q, l_d;
    logic [OW:0]     sum, idx;

    dscan_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk_i    (CLK),
        .rst_i    (RST),
        .enable_i (ENABLE),
        .step_o   (step)
    );

    assign frame_end = step && (sub_q == SUB_LAST) && (slot_q == SLOT_LAST);

    always_comb begin
        sub_d  = sub_q;
        slot_d = slot_q;
        ofs_d  = ofs_q;
        if (step) begin
            sub_d = sub_q + 1'b1;
            if (sub_q == SUB_LAST) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end
        end
        // Offset only moves at frame start so a frame never tears.
        if (frame_end && ({1'b0, OFS} < NDATA_W)) begin
            ofs_d = OFS;
        end
    end

`ifdef DSCAN_BLINK_EN
    logic [FRAME_W-1:0] frame_q, frame_d;

    assign frame_d    = frame_end ? frame_q + 1'b1 : frame_q;
    assign blink_dark = frame_q[FRAME_W-1] & BLINK[slot_q];

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end
`else
    assign blink_dark = 1'b0;
`endif

    // ofs_q < NDATA and slot < WIN <= NDATA, so one conditional subtract
    // is enough to wrap the index.
    always_comb begin
        sum  = {1'b0, ofs_q} + (OW + 1)'(slot_q);
        idx  = (sum >= NDATA_W) ? sum - NDATA_W : sum;
        lit  = (sub_q < BRIGHT) && !blink_dark;
        sa_d = lit ? WIN'(one_cold(5'(slot_q))) : WIN'(sa_off());
        l_d  = lit ? D[idx*DW +: DW] : l_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sub_q  <= '0;
            slot_q <= '0;
            ofs_q  <= '0;
            sa_q   <= '1;
            l_q    <= '0;
        end else begin
            sub_q  <= sub_d;
            slot_q <= slot_d;
            ofs_q  <= ofs_d;
            sa_q   <= sa_d;
            l_q    <= l_d;
        end
    end

    assign SA = sa_q;
    assign L  = l_q;

endmodule

// File: tb/tb_dscan_mux.sv
// Scoreboard bench for dscan_mux: two instances (DIV=1 and DIV=3) share the
// same stimulus; a reference model derived from the enabled-cycle count pushes
// expected outputs into a queue and a negedge monitor compares them.
module tb_dscan_mux;

    localparam int WIN   = 4;
    localparam int NDATA = 6;
    localparam int DW    = 4;
    localparam int OW    = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic [23:0] D = '0;
    logic [2:0]  OFS = '0;
    logic [2:0]  BRIGHT = '0;
    logic [3:0]  SA1, SA3;
    logic [3:0]  L1, L3;

    always #5 CLK = ~CLK;

    dscan_mux #(.WIN(WIN), .NDATA(NDATA), .DW(DW), .DIV(1), .OW(OW)) u_div1 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .D(D), .OFS(OFS), .BRIGHT(BRIGHT),
        .SA(SA1), .L(L1)
    );

    dscan_mux #(.WIN(WIN), .NDATA(NDATA), .DW(DW), .DIV(3), .OW(OW)) u_div3 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .D(D), .OFS(OFS), .BRIGHT(BRIGHT),
        .SA(SA3), .L(L3)
    );

    typedef struct packed {
        logic [3:0] sa1;
        logic [3:0] l1;
        logic [3:0] sa3;
        logic [3:0] l3;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: position in the scan follows from how many enabled
    // cycles have passed since reset.
    int         divs[2] = '{1, 3};
    int         n_en[2];
    int         mofs[2];
    logic [3:0] ml[2];
    logic [3:0] esa[2];

    function automatic logic [3:0] nib(input logic [23:0] d, input int i);
        logic [23:0] t;
        t = d >> (4 * i);
        return t[3:0];
    endfunction

    task automatic model(input bit rst, input bit en, input int br, input int ofs,
                         input logic [23:0] d);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                n_en[k] = 0;
                mofs[k] = 0;
                ml[k]   = 4'h0;
                esa[k]  = 4'hF;
            end else begin
                int s, pos, slot, sub, s2;
                s    = n_en[k] / divs[k];
                pos  = s % (8 * WIN);
                slot = pos / 8;
                sub  = pos % 8;
                if (sub < br) begin
                    esa[k] = ~(4'b0001 << slot);
                    ml[k]  = nib(d, (mofs[k] + slot) % NDATA);
                end else begin
                    esa[k] = 4'hF;
                end
                if (en) begin
                    n_en[k] = n_en[k] + 1;
                    s2 = n_en[k] / divs[k];
                    if (s2 != s && (s2 % (8 * WIN)) == 0 && ofs < NDATA)
                        mofs[k] = ofs;
                end
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input int br, input int ofs,
                       input logic [23:0] d);
        exp_t e;
        RST    = rst;
        ENABLE = en;
        BRIGHT = 3'(br);
        OFS    = 3'(ofs);
        D      = d;
        model(rst, en, br, ofs, d);
        e.sa1 = esa[0];
        e.l1  = ml[0];
        e.sa3 = esa[1];
        e.l3  = ml[1];
        @(posedge CLK);
        q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sa_div1", SA1, e.sa1);
                chk("l_div1",  L1,  e.l1);
                chk("sa_div3", SA3, e.sa3);
                chk("l_div3",  L3,  e.l3);
            end
        end
    end

    initial begin
        logic [23:0] d_seq;
        logic [23:0] d_rnd;
        int          br_r, ofs_r;
        d_seq = 24'h654321;
        @(negedge CLK);

        // reset with random data: outputs dark, L=0
        repeat (3) cyc(1, 1, 4, 0, 24'($urandom));

        // basic scan, offset 0
        repeat (40) cyc(0, 1, 4, 0, d_seq);
        // offset 4 requested mid-frame, then an out-of-range offset
        repeat (120) cyc(0, 1, 4, 4, d_seq);
        repeat (200) cyc(0, 1, 4, 7, d_seq);

        // brightness bounds
        repeat (100) cyc(0, 1, 0, 2, d_seq);
        repeat (200) cyc(0, 1, 7, 1, d_seq);

        // freeze mid-slot with live data changes
        repeat (5) cyc(0, 1, 7, 0, d_seq);
        repeat (10) cyc(0, 0, 7, 0, 24'($urandom));
        repeat (60) cyc(0, 1, 7, 0, d_seq);

        // reset pulse at slot 2 of the DIV=1 instance
        cyc(1, 1, 5, 3, d_seq);
        repeat (18) cyc(0, 1, 5, 3, d_seq);
        cyc(1, 1, 5, 3, d_seq);
        repeat (40) cyc(0, 1, 5, 3, d_seq);

        // randomized operation
        d_rnd = 24'($urandom);
        br_r  = 4;
        ofs_r = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) d_rnd = 24'($urandom);
            if ($urandom_range(0, 40) == 0) br_r = $urandom_range(0, 7);
            if ($urandom_range(0, 20) == 0) ofs_r = $urandom_range(0, 7);
            cyc($urandom_range(0, 400) == 0, $urandom_range(0, 5) != 0,
                br_r, ofs_r, d_rnd);
        end

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge CLK);
        @(negedge CLK);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d expected=0 entries left", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
